// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO arbiter controller.
package fifo_ctrl_pkg;

  localparam int unsigned StateW      = 3;
  localparam int unsigned DefAeThr    = 1;
  // Default almost-full threshold is FIFO_DEPTH minus this margin.
  localparam int unsigned AfThrMargin = 2;

  typedef enum logic [StateW-1:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_sel.sv
// Combinational winner select over a request vector.
// Round-robin from ptr_i+1 by default; ARB_STRICT_PRIO_EN selects lowest-index-wins.
module rr_grant_sel #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

`ifdef ARB_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  always_comb begin : p_sel
    int unsigned j;
    j           = 0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    // Scan farthest candidate first so the nearest requester overwrites it.
    for (int unsigned k = N; k >= 1; k--) begin
`ifdef ARB_STRICT_PRIO_EN
      j = k - 1;
`else
      j = (32'(ptr_i) + k) % N;
`endif
      if (req_i[j[IdxW-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = j[IdxW-1:0];
      end
    end
    gnt_o = '0;
    if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/fifo_arbiter_ctrl.sv
// Drains NUM_FIFOS input FIFOs into one output FIFO, one word per cycle, after threshold init.
// Define ARB_STRICT_PRIO_EN for fixed priority instead of round-robin arbitration.
module fifo_arbiter_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FIFOS      = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FIFO_WORD_SIZE = 10,
  parameter int unsigned FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [FIFO_PTR_SIZE-1:0]      almost_empty_threshold_input,
  input  logic [FIFO_PTR_SIZE-1:0]      almost_full_threshold_input,
  input  logic [NUM_FIFOS-1:0]          in_empty,
  input  logic [NUM_FIFOS-1:0]          in_error,
  input  logic [NUM_FIFOS*FIFO_WORD_SIZE-1:0] in_data,
  input  logic                          out_almost_full,
  input  logic                          out_full,
  input  logic                          out_error,
  output logic [NUM_FIFOS-1:0]          in_rd_en,
  output logic                          out_wr_en,
  output logic [FIFO_WORD_SIZE-1:0]     out_data,
  output logic [FIFO_PTR_SIZE-1:0]      almost_empty_threshold,
  output logic [FIFO_PTR_SIZE-1:0]      almost_full_threshold,
  output logic [StateW-1:0]             state,
  output logic                          idle,
  output logic                          error_flag
);

  localparam int unsigned IdxW = idx_width(NUM_FIFOS);

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            ptr_q, ptr_d;
  logic [IdxW-1:0]            widx_q, widx_d;
  logic                       out_wr_en_q, out_wr_en_d;
  logic                       idle_q, idle_d;
  logic                       error_flag_q, error_flag_d;
  logic [FIFO_PTR_SIZE-1:0]   ae_thr_q, ae_thr_d;
  logic [FIFO_PTR_SIZE-1:0]   af_thr_q, af_thr_d;

  logic [NUM_FIFOS-1:0]       gnt;
  logic [IdxW-1:0]            gnt_idx;
  logic                       gnt_valid;
  logic                       err_cond;
  logic                       pop;

  logic [FIFO_WORD_SIZE-1:0]  in_words [NUM_FIFOS];

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_words
    assign in_words[gi] = in_data[gi*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
  end

  rr_grant_sel #(
    .N    (NUM_FIFOS),
    .IdxW (IdxW)
  ) u_grant_sel (
    .req_i       (~in_empty),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    err_cond = (|in_error) | out_error | (out_wr_en_q & out_full);
    // Almost-full gating leaves room for the word already in flight.
    pop = !reset && gnt_valid && !out_almost_full && !out_full && !err_cond &&
          ((state_q == StIdle && !init) || state_q == StActive);
    in_rd_en = pop ? gnt : '0;

    state_d  = state_q;
    ae_thr_d = ae_thr_q;
    af_thr_d = af_thr_q;
    unique case (state_q)
      StReset:  state_d = StInit;
      StInit: begin
        if (init) begin
          ae_thr_d = almost_empty_threshold_input;
          af_thr_d = almost_full_threshold_input;
        end else begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (init)           state_d = StInit;
        else if (gnt_valid) state_d = StActive;
      end
      // All empty implies no pop this cycle, so nothing remains in flight afterwards.
      StActive: if (!gnt_valid) state_d = StIdle;
      StError:  state_d = StError;
      default:  state_d = StError;
    endcase
    if (state_q != StReset && err_cond) state_d = StError;

    ptr_d        = pop ? gnt_idx : ptr_q;
    widx_d       = pop ? gnt_idx : widx_q;
    out_wr_en_d  = pop;
    idle_d       = (state_d == StIdle);
    error_flag_d = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReset;
      ptr_q        <= IdxW'(NUM_FIFOS - 1);
      widx_q       <= '0;
      out_wr_en_q  <= 1'b0;
      idle_q       <= 1'b0;
      error_flag_q <= 1'b0;
      ae_thr_q     <= FIFO_PTR_SIZE'(DefAeThr);
      af_thr_q     <= FIFO_PTR_SIZE'(FIFO_DEPTH - AfThrMargin);
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      widx_q       <= widx_d;
      out_wr_en_q  <= out_wr_en_d;
      idle_q       <= idle_d;
      error_flag_q <= error_flag_d;
      ae_thr_q     <= ae_thr_d;
      af_thr_q     <= af_thr_d;
    end
  end

  assign out_wr_en              = out_wr_en_q;
  assign out_data               = out_wr_en_q ? in_words[widx_q] : '0;
  assign almost_empty_threshold = ae_thr_q;
  assign almost_full_threshold  = af_thr_q;
  assign state                  = state_q;
  assign idle                   = idle_q;
  assign error_flag             = error_flag_q;

endmodule
